timer_host_ctrl: RTL and testbench

- Avalon-MM initiator that drives the 16-bit interval-timer slave (6-register map, no waitrequest, registered readdata) in the alarm-clock SoC.
- Programs period and interrupt enable after reset, then services each timeout IRQ by clearing status and advancing a seconds-of-day counter.
- Handles period reloads and counter snapshots on request, so the fabric keeps time without CPU involvement.

---
 rtl/timer_host_pkg.sv | 31 +++
 rtl/tick_wrap_counter.sv | 22 ++
 rtl/timer_host_ctrl.sv | 136 +++++++++++++
 tb/tb_timer_host_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_host_pkg.sv
// Shared register map, bus request payload and FSM encoding for the
// interval-timer host controller.
package timer_host_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERL   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PERH   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_SNAPL  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_SNAPH  = 3'd5;

    localparam logic [DATA_W-1:0] CTRL_ITO = 16'h0001;

    typedef struct packed {
        logic              cs;
        logic              write_n;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } av_req_t;

    localparam av_req_t AV_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: '0, wdata: '0};

    typedef enum logic [3:0] {
        INIT_PL, INIT_PH, INIT_CTRL, IDLE, ACK, LD_PL, LD_PH,
        SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP
    } state_t;

endpackage

// File: rtl/tick_wrap_counter.sv
// Seconds-of-day counter: increments on inc, wraps to 0 after DAY_TICKS-1.
module tick_wrap_counter #(
    parameter int unsigned TICK_W    = 17,
    parameter int unsigned DAY_TICKS = 86400
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc,
    output logic [TICK_W-1:0] count
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(DAY_TICKS - 1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc) begin
            count <= (count == LAST) ? '0 : count + TICK_W'(1);
        end
    end

endmodule

// File: rtl/timer_host_ctrl.sv
// Avalon-MM initiator that initialises the interval timer, services its
// timeout IRQ into a seconds-of-day count, and handles reloads/snapshots.
module timer_host_ctrl
    import timer_host_pkg::*;
#(
    parameter logic [31:0] PERIOD_DEFAULT = 32'd49_999_999,
    parameter int unsigned DAY_TICKS      = 86400,
    parameter int unsigned TICK_W         = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_load,
    input  logic              snap_req,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic [TICK_W-1:0] tick_count,
    output logic              tick_pulse,
    output logic              busy,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              timer_irq
);

    state_t      state, next_state;
    av_req_t     av_q, req_c;
    logic        started;
    logic [31:0] shadow, shadow_c;
    logic        load_pend, snap_pend;
    logic        load_take_c, snap_take_c, tick_inc_c;
    logic [15:0] snap_lo;

    // The bus request is computed for the state being entered, so the
    // registered strobe lines up with the state that owns the access.
    always_comb begin
        next_state  = state;
        req_c       = AV_IDLE;
        shadow_c    = cfg_load ? cfg_period : shadow;
        load_take_c = 1'b0;
        snap_take_c = 1'b0;

        case (state)
            INIT_PL:   if (started) next_state = INIT_PH;
            INIT_PH:   next_state = INIT_CTRL;
            INIT_CTRL: next_state = IDLE;
            IDLE: begin
                if (timer_irq) begin
                    next_state = ACK;
                end else if (load_pend || cfg_load) begin
                    next_state  = LD_PL;
                    load_take_c = 1'b1;
                end else if (snap_pend || snap_req) begin
                    next_state  = SNAP_W;
                    snap_take_c = 1'b1;
                end
            end
            ACK:      next_state = IDLE;
            LD_PL:    next_state = LD_PH;
            LD_PH:    next_state = IDLE;
            SNAP_W:   next_state = SNAP_RL;
            SNAP_RL:  next_state = SNAP_RH;
            SNAP_RH:  next_state = SNAP_CAP;
            SNAP_CAP: next_state = IDLE;
            default:  next_state = INIT_PL;
        endcase

        case (next_state)
            INIT_PL:   req_c = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_PERL,   wdata: PERIOD_DEFAULT[15:0]};
            INIT_PH:   req_c = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_PERH,   wdata: PERIOD_DEFAULT[31:16]};
            INIT_CTRL: req_c = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_CTRL,   wdata: CTRL_ITO};
            ACK:       req_c = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_STATUS, wdata: 16'h0000};
            LD_PL:     req_c = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_PERL,   wdata: shadow_c[15:0]};
            LD_PH:     req_c = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_PERH,   wdata: shadow_c[31:16]};
            SNAP_W:    req_c = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_SNAPL,  wdata: 16'h0000};
            SNAP_RL:   req_c = '{cs: 1'b1, write_n: 1'b1, addr: ADDR_SNAPL,  wdata: 16'h0000};
            SNAP_RH:   req_c = '{cs: 1'b1, write_n: 1'b1, addr: ADDR_SNAPH,  wdata: 16'h0000};
            default:   req_c = AV_IDLE;
        endcase

        tick_inc_c = (next_state == ACK);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= INIT_PL;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs, request bookkeeping and snapshot assembly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            started    <= 1'b0;
            av_q       <= AV_IDLE;
            busy       <= 1'b1;
            tick_pulse <= 1'b0;
            snap_valid <= 1'b0;
            snap_value <= '0;
            snap_lo    <= '0;
            shadow     <= '0;
            load_pend  <= 1'b0;
            snap_pend  <= 1'b0;
        end else begin
            started    <= 1'b1;
            av_q       <= req_c;
            busy       <= (next_state != IDLE);
            tick_pulse <= tick_inc_c;
            shadow     <= shadow_c;
            load_pend  <= (load_pend | cfg_load) & ~load_take_c;
            snap_pend  <= (snap_pend | snap_req) & ~snap_take_c;
            snap_valid <= (state == SNAP_CAP);
            if (state == SNAP_RH) snap_lo <= av_readdata;
            if (state == SNAP_CAP) snap_value <= {av_readdata, snap_lo};
        end
    end

    assign av_chipselect = av_q.cs;
    assign av_write_n    = av_q.write_n;
    assign av_address    = av_q.addr;
    assign av_writedata  = av_q.wdata;

    tick_wrap_counter #(
        .TICK_W    (TICK_W),
        .DAY_TICKS (DAY_TICKS)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (tick_inc_c),
        .count   (tick_count)
    );

endmodule

// File: tb/tb_timer_host_ctrl.sv
// Directed bench for timer_host_ctrl with a behavioural interval-timer slave;
// a second instance uses DAY_TICKS=4 to exercise the day wrap.
module tb_timer_host_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cfg_period = 32'd0;
    logic        cfg_load = 1'b0;
    logic        snap_req = 1'b0;
    logic [15:0] av_readdata;
    logic        timer_irq;

    logic [31:0] snap_value, snap_value4;
    logic        snap_valid, snap_valid4;
    logic [16:0] tick_count, tick_count4;
    logic        tick_pulse, tick_pulse4;
    logic        busy, busy4;
    logic [2:0]  av_address, av_address4;
    logic        av_chipselect, av_chipselect4;
    logic        av_write_n, av_write_n4;
    logic [15:0] av_writedata, av_writedata4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    timer_host_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_load(cfg_load),
        .snap_req(snap_req), .snap_value(snap_value), .snap_valid(snap_valid),
        .tick_count(tick_count), .tick_pulse(tick_pulse), .busy(busy),
        .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
        .av_writedata(av_writedata), .av_readdata(av_readdata), .timer_irq(timer_irq)
    );

    timer_host_ctrl #(.DAY_TICKS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_load(cfg_load),
        .snap_req(snap_req), .snap_value(snap_value4), .snap_valid(snap_valid4),
        .tick_count(tick_count4), .tick_pulse(tick_pulse4), .busy(busy4),
        .av_address(av_address4), .av_chipselect(av_chipselect4), .av_write_n(av_write_n4),
        .av_writedata(av_writedata4), .av_readdata(av_readdata), .timer_irq(timer_irq)
    );

    // Behavioural slave, driven by the main instance's bus.
    logic        irq_en = 1'b0;
    logic        force_to = 1'b0;
    logic        timeout = 1'b0;
    logic        ito = 1'b0;
    logic [3:0]  cnt = 4'd9;
    logic [31:0] per_reg = 32'd0;
    logic [31:0] snap_reg = 32'd0;
    logic [31:0] snap_src = 32'h0001_2345;
    logic [15:0] rdata = 16'd0;
    int          reads = 0;
    int          sv_pulses = 0;

    always @(posedge clk) begin
        if (irq_en) begin
            if (cnt == 4'd0) begin
                timeout <= 1'b1;
                cnt     <= 4'd9;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
        if (force_to) timeout <= 1'b1;
        if (av_chipselect) begin
            if (!av_write_n) begin
                case (av_address)
                    3'd0: timeout <= 1'b0;
                    3'd1: ito <= av_writedata[0];
                    3'd2: per_reg[15:0] <= av_writedata;
                    3'd3: per_reg[31:16] <= av_writedata;
                    3'd4, 3'd5: snap_reg <= snap_src;
                    default: ;
                endcase
            end else begin
                reads <= reads + 1;
                case (av_address)
                    3'd4:    rdata <= snap_reg[15:0];
                    3'd5:    rdata <= snap_reg[31:16];
                    default: rdata <= 16'h0000;
                endcase
            end
        end
        if (snap_valid) sv_pulses <= sv_pulses + 1;
    end

    assign av_readdata = rdata;
    assign timer_irq   = timeout & ito;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bv(input logic cs, input logic wn,
                                       input logic [2:0] a, input logic [15:0] d);
        return {11'd0, cs, wn, a, d};
    endfunction

    task automatic bus_chk(input string tag, input logic [31:0] exp);
        chk(tag, {11'd0, av_chipselect, av_write_n, av_address, av_writedata}, exp);
        chk({tag, "/d4"}, {11'd0, av_chipselect4, av_write_n4, av_address4, av_writedata4}, exp);
    endtask

    task automatic busy_chk(input string tag, input logic exp);
        chk(tag, {31'd0, busy}, {31'd0, exp});
        chk({tag, "/d4"}, {31'd0, busy4}, {31'd0, exp});
    endtask

    task automatic init_chk(input string tag);
        @(negedge clk); bus_chk({tag, "_pl"}, bv(1, 0, 3'd2, 16'hF07F)); busy_chk({tag, "_busy1"}, 1'b1);
        @(negedge clk); bus_chk({tag, "_ph"}, bv(1, 0, 3'd3, 16'h02FA));
        @(negedge clk); bus_chk({tag, "_ctrl"}, bv(1, 0, 3'd1, 16'h0001)); busy_chk({tag, "_busy3"}, 1'b1);
        @(negedge clk); bus_chk({tag, "_idle"}, bv(0, 1, 3'd0, 16'h0000)); busy_chk({tag, "_busy4"}, 1'b0);
    endtask

    initial begin
        logic got;
        int   sv_before;

        // Reset values
        repeat (2) @(negedge clk);
        bus_chk("rst_bus", bv(0, 1, 3'd0, 16'h0000));
        busy_chk("rst_busy", 1'b1);
        chk("rst_tick", 32'(tick_count), 32'd0);
        chk("rst_snapv", {31'd0, snap_valid}, 32'd0);
        chk("rst_snapval", snap_value, 32'd0);
        chk("rst_pulse", {31'd0, tick_pulse}, 32'd0);

        // Init sequence
        reset_n = 1'b1;
        init_chk("init");
        chk("init_reads", 32'(reads), 32'd0);
        chk("init_period", per_reg, 32'h02FA_F07F);
        chk("init_ito", {31'd0, ito}, 32'd1);

        // Six timeouts: ACK write, pulse, counter and day wrap (DAY_TICKS=4)
        irq_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            got = 1'b0;
            for (int k = 0; k < 30 && !got; k++) begin
                @(negedge clk);
                if (timer_irq) got = 1'b1;
            end
            chk("irq_seen", {31'd0, got}, 32'd1);
            @(negedge clk);
            bus_chk("ack_bus", bv(1, 0, 3'd0, 16'h0000));
            chk("ack_pulse", {31'd0, tick_pulse}, 32'd1);
            chk("ack_pulse/d4", {31'd0, tick_pulse4}, 32'd1);
            chk("ack_tick", 32'(tick_count), 32'(i + 1));
            chk("ack_tick/d4", 32'(tick_count4), 32'((i + 1) % 4));
        end
        irq_en = 1'b0;
        @(negedge clk);
        bus_chk("ack_done", bv(0, 1, 3'd0, 16'h0000));
        chk("ack_pulse_low", {31'd0, tick_pulse}, 32'd0);
        @(negedge clk);
        chk("irq_cleared", {31'd0, timer_irq}, 32'd0);
        chk("tick_after5", 32'(tick_count), 32'd6);

        // Snapshot of a frozen counter
        snap_src = 32'h0001_2345;
        snap_req = 1'b1;
        @(negedge clk); snap_req = 1'b0;
        bus_chk("snap_w", bv(1, 0, 3'd4, 16'h0000));
        @(negedge clk); bus_chk("snap_rl", bv(1, 1, 3'd4, 16'h0000));
        @(negedge clk); bus_chk("snap_rh", bv(1, 1, 3'd5, 16'h0000));
        @(negedge clk); bus_chk("snap_cap", bv(0, 1, 3'd0, 16'h0000));
        chk("snap_v_early", {31'd0, snap_valid}, 32'd0);
        @(negedge clk);
        chk("snap_valid", {31'd0, snap_valid}, 32'd1);
        chk("snap_value", snap_value, 32'h0001_2345);
        chk("snap_value/d4", snap_value4, 32'h0001_2345);
        busy_chk("snap_busy", 1'b0);
        @(negedge clk);
        chk("snap_v_pulse", {31'd0, snap_valid}, 32'd0);
        chk("snap_reads", 32'(reads), 32'd2);

        // irq + cfg_load together, snap_req during ACK
        snap_src = 32'h0000_BEEF;
        force_to = 1'b1;
        @(negedge clk); force_to = 1'b0;
        cfg_period = 32'h0000_0063; cfg_load = 1'b1;
        @(negedge clk); cfg_load = 1'b0; cfg_period = 32'hFFFF_FFFF; snap_req = 1'b1;
        bus_chk("mix_ack", bv(1, 0, 3'd0, 16'h0000));
        chk("mix_tick", 32'(tick_count), 32'd7);
        chk("mix_tick/d4", 32'(tick_count4), 32'd3);
        @(negedge clk); snap_req = 1'b0;
        bus_chk("mix_idle1", bv(0, 1, 3'd0, 16'h0000));
        @(negedge clk); bus_chk("mix_ldpl", bv(1, 0, 3'd2, 16'h0063));
        @(negedge clk); bus_chk("mix_ldph", bv(1, 0, 3'd3, 16'h0000));
        @(negedge clk); bus_chk("mix_idle2", bv(0, 1, 3'd0, 16'h0000));
        chk("mix_period", per_reg, 32'h0000_0063);
        @(negedge clk); bus_chk("mix_snap_w", bv(1, 0, 3'd4, 16'h0000));
        @(negedge clk); bus_chk("mix_snap_rl", bv(1, 1, 3'd4, 16'h0000));
        @(negedge clk); bus_chk("mix_snap_rh", bv(1, 1, 3'd5, 16'h0000));
        @(negedge clk); bus_chk("mix_snap_cap", bv(0, 1, 3'd0, 16'h0000));
        @(negedge clk);
        chk("mix_snap_valid", {31'd0, snap_valid}, 32'd1);
        chk("mix_snap_value", snap_value, 32'h0000_BEEF);
        @(negedge clk);
        bus_chk("mix_quiet", bv(0, 1, 3'd0, 16'h0000));
        chk("mix_tick_once", 32'(tick_count), 32'd7);

        // Reset during SNAP_RL
        sv_before = sv_pulses;
        snap_req = 1'b1;
        @(negedge clk); snap_req = 1'b0;
        bus_chk("rsnap_w", bv(1, 0, 3'd4, 16'h0000));
        @(negedge clk);
        bus_chk("rsnap_rl", bv(1, 1, 3'd4, 16'h0000));
        reset_n = 1'b0;
        @(negedge clk);
        bus_chk("rsnap_bus", bv(0, 1, 3'd0, 16'h0000));
        busy_chk("rsnap_busy", 1'b1);
        chk("rsnap_tick", 32'(tick_count), 32'd0);
        chk("rsnap_sv", {31'd0, snap_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        init_chk("reinit");
        repeat (3) @(negedge clk);
        bus_chk("reinit_quiet", bv(0, 1, 3'd0, 16'h0000));
        chk("rsnap_no_valid", 32'(sv_pulses - sv_before), 32'd0);
        chk("rsnap_value", snap_value, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
